// File: rtl/gps_rx_pkg.sv
// gps_rx_pkg: shared types and constants for the GPS C/A code acquisition block.
//   acq_state_e : search state machine encoding
//   tap_pair_t  : G2 phase-selector tap pair (stage numbers 1..10)
//   sv_taps()   : per-SV G2 tap table, SV1..SV32
//   phase_inc() : code-phase increment, wrapping 1022 -> 0
package gps_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_SLIP,
    ST_LOCK,
    ST_FAIL
  } acq_state_e;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
  } tap_pair_t;

  localparam logic [9:0] G1_INIT   = 10'h3FF;
  localparam logic [9:0] G2_INIT   = 10'h3FF;
  localparam logic [5:0] SV_MIN    = 6'd1;
  localparam logic [5:0] SV_MAX    = 6'd32;
  localparam logic [9:0] PHASE_MAX = 10'd1022;

  // G2 phase-selector taps for each satellite.
  function automatic tap_pair_t sv_taps(input logic [5:0] sv);
    tap_pair_t tp;
    case (sv)
      6'd1:    tp = {4'd2, 4'd6};
      6'd2:    tp = {4'd3, 4'd7};
      6'd3:    tp = {4'd4, 4'd8};
      6'd4:    tp = {4'd5, 4'd9};
      6'd5:    tp = {4'd1, 4'd9};
      6'd6:    tp = {4'd2, 4'd10};
      6'd7:    tp = {4'd1, 4'd8};
      6'd8:    tp = {4'd2, 4'd9};
      6'd9:    tp = {4'd3, 4'd10};
      6'd10:   tp = {4'd2, 4'd3};
      6'd11:   tp = {4'd3, 4'd4};
      6'd12:   tp = {4'd5, 4'd6};
      6'd13:   tp = {4'd6, 4'd7};
      6'd14:   tp = {4'd7, 4'd8};
      6'd15:   tp = {4'd8, 4'd9};
      6'd16:   tp = {4'd9, 4'd10};
      6'd17:   tp = {4'd1, 4'd4};
      6'd18:   tp = {4'd2, 4'd5};
      6'd19:   tp = {4'd3, 4'd6};
      6'd20:   tp = {4'd4, 4'd7};
      6'd21:   tp = {4'd5, 4'd8};
      6'd22:   tp = {4'd6, 4'd9};
      6'd23:   tp = {4'd1, 4'd3};
      6'd24:   tp = {4'd4, 4'd6};
      6'd25:   tp = {4'd5, 4'd7};
      6'd26:   tp = {4'd6, 4'd8};
      6'd27:   tp = {4'd7, 4'd9};
      6'd28:   tp = {4'd8, 4'd10};
      6'd29:   tp = {4'd1, 4'd6};
      6'd30:   tp = {4'd2, 4'd7};
      6'd31:   tp = {4'd3, 4'd8};
      6'd32:   tp = {4'd4, 4'd9};
      default: tp = {4'd2, 4'd6};
    endcase
    return tp;
  endfunction

  function automatic logic [9:0] phase_inc(input logic [9:0] p);
    return (p == PHASE_MAX) ? 10'd0 : p + 10'd1;
  endfunction

endpackage

// File: rtl/gps_ca_acquire_if.sv
// gps_ca_acquire_if: control, chip stream and status bundle of gps_ca_acquire.
//   sv_num/start          : search request (master -> slave)
//   chip_in/chip_valid    : received chip stream (master -> slave)
//   lock/fail/done        : search status (slave -> master)
//   code_phase/corr_count : slip count and last window agreement count
interface gps_ca_acquire_if;
  logic [5:0]  sv_num;
  logic        start;
  logic        chip_in;
  logic        chip_valid;
  logic        lock;
  logic        fail;
  logic        done;
  logic [9:0]  code_phase;
  logic [10:0] corr_count;

  modport master (
    output sv_num, start, chip_in, chip_valid,
    input  lock, fail, done, code_phase, corr_count
  );

  modport slave (
    input  sv_num, start, chip_in, chip_valid,
    output lock, fail, done, code_phase, corr_count
  );
endinterface

// File: rtl/gps_rx_cagen.sv
// gps_rx_cagen: local C/A code generator (G1/G2 LFSR pair).
//   clk, rst : clock, asynchronous active-high reset
//   load     : reload both registers with all-ones (wins over advance)
//   advance  : step both registers by one chip
//   taps     : G2 phase-selector tap pair for the selected SV
//   chip     : current local chip, G1[10] ^ G2[s1] ^ G2[s2]
module gps_rx_cagen
  import gps_rx_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      advance,
  input  tap_pair_t taps,
  output logic      chip
);

  // Stage numbering follows the ICD: stage 1 is the input, stage 10 the output.
  logic [10:1] g1_q, g1_d;
  logic [10:1] g2_q, g2_d;

  always_comb begin
    g1_d = g1_q;
    g2_d = g2_q;
    if (load) begin
      g1_d = G1_INIT;
      g2_d = G2_INIT;
    end else if (advance) begin
      g1_d = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
      g2_d = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1_q <= G1_INIT;
      g2_q <= G2_INIT;
    end else begin
      g1_q <= g1_d;
      g2_q <= g2_d;
    end
  end

  assign chip = g1_q[10] ^ g2_q[taps.s1] ^ g2_q[taps.s2];

endmodule

// File: rtl/gps_ca_acquire.sv
// gps_ca_acquire: serial C/A code-phase search for one SV.
//   gps_clk_fast : clock, rising edge
//   sync_rst_in  : asynchronous active-high reset
//   bus (slave)  : sv_num/start request, chip_in/chip_valid stream,
//                  lock/fail/done status, code_phase, corr_count
// Each window of CORR_LEN valid chips counts agreements with the local code.
// A failed window slips the local code one chip (one received chip is
// dropped without advancing the generator) and the search continues.
// Optional build macro GPS_CORR_TRACK_EN: keep correlating while locked and
// fall back to searching (phase wrapping 1022 -> 0) when a window misses.
module gps_ca_acquire
  import gps_rx_pkg::*;
#(
  parameter int CORR_LEN = 64,
  parameter int THRESH   = 56
)(
  input  logic            gps_clk_fast,
  input  logic            sync_rst_in,
  gps_ca_acquire_if.slave bus
);

  localparam logic [9:0]  WIN_LAST = 10'(CORR_LEN - 1);
  localparam logic [10:0] THRESH_C = 11'(THRESH);

  acq_state_e  state_q, state_d;
  logic [9:0]  code_phase_q, code_phase_d;
  logic [9:0]  win_q, win_d;
  logic [10:0] agree_q, agree_d;
  logic [10:0] corr_q, corr_d;
  logic        lock_q, lock_d;
  logic        fail_q, fail_d;
  logic        done_q, done_d;
  tap_pair_t   taps_q, taps_d;
`ifdef GPS_CORR_TRACK_EN
  // Failed windows since the search (re)started; phase wraps, so it can
  // no longer double as the give-up counter.
  logic [9:0]  miss_q, miss_d;
`endif

  logic        gen_load;
  logic        gen_adv;
  logic        local_chip;
  logic        sv_ok;
  logic        win_end;
  logic        give_up;
  logic [10:0] agree_inc;

  gps_rx_cagen u_cagen (
    .clk     (gps_clk_fast),
    .rst     (sync_rst_in),
    .load    (gen_load),
    .advance (gen_adv),
    .taps    (taps_q),
    .chip    (local_chip)
  );

  always_comb begin
    state_d      = state_q;
    code_phase_d = code_phase_q;
    win_d        = win_q;
    agree_d      = agree_q;
    corr_d       = corr_q;
    lock_d       = lock_q;
    fail_d       = fail_q;
    done_d       = 1'b0;
    taps_d       = taps_q;
    gen_load     = 1'b0;
    gen_adv      = 1'b0;
    sv_ok        = (bus.sv_num >= SV_MIN) && (bus.sv_num <= SV_MAX);
    win_end      = (win_q == WIN_LAST);
    agree_inc    = agree_q + {10'd0, (bus.chip_in == local_chip)};
`ifdef GPS_CORR_TRACK_EN
    miss_d       = miss_q;
    give_up      = (miss_q == PHASE_MAX);
`else
    give_up      = (code_phase_q == PHASE_MAX);
`endif

    if (bus.start) begin
      // Restart from any state; a chip arriving alongside start is dropped.
      gen_load     = 1'b1;
      code_phase_d = '0;
      win_d        = '0;
      agree_d      = '0;
      lock_d       = 1'b0;
`ifdef GPS_CORR_TRACK_EN
      miss_d       = '0;
`endif
      if (sv_ok) begin
        state_d = ST_SEARCH;
        fail_d  = 1'b0;
        taps_d  = sv_taps(bus.sv_num);
      end else begin
        state_d = ST_FAIL;
        fail_d  = 1'b1;
        done_d  = 1'b1;
      end
    end else if (bus.chip_valid) begin
      case (state_q)
        ST_SEARCH: begin
          gen_adv = 1'b1;
          if (win_end) begin
            win_d   = '0;
            agree_d = '0;
            corr_d  = agree_inc;
            if (agree_inc >= THRESH_C) begin
              state_d = ST_LOCK;
              lock_d  = 1'b1;
              done_d  = 1'b1;
            end else if (give_up) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d      = ST_SLIP;
              code_phase_d = phase_inc(code_phase_q);
`ifdef GPS_CORR_TRACK_EN
              miss_d       = miss_q + 10'd1;
`endif
            end
          end else begin
            win_d   = win_q + 10'd1;
            agree_d = agree_inc;
          end
        end

        // Swallow one chip with the generator frozen: local code falls one chip behind.
        ST_SLIP: state_d = ST_SEARCH;

        ST_LOCK: begin
          gen_adv = 1'b1;
          if (win_end) begin
            win_d   = '0;
            agree_d = '0;
`ifdef GPS_CORR_TRACK_EN
            corr_d  = agree_inc;
            if (agree_inc < THRESH_C) begin
              state_d      = ST_SLIP;
              lock_d       = 1'b0;
              code_phase_d = phase_inc(code_phase_q);
              miss_d       = '0;
            end
`endif
          end else begin
            win_d   = win_q + 10'd1;
            agree_d = agree_inc;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge gps_clk_fast or posedge sync_rst_in) begin
    if (sync_rst_in) begin
      state_q      <= ST_IDLE;
      code_phase_q <= '0;
      win_q        <= '0;
      agree_q      <= '0;
      corr_q       <= '0;
      lock_q       <= 1'b0;
      fail_q       <= 1'b0;
      done_q       <= 1'b0;
      taps_q       <= sv_taps(SV_MIN);
`ifdef GPS_CORR_TRACK_EN
      miss_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      code_phase_q <= code_phase_d;
      win_q        <= win_d;
      agree_q      <= agree_d;
      corr_q       <= corr_d;
      lock_q       <= lock_d;
      fail_q       <= fail_d;
      done_q       <= done_d;
      taps_q       <= taps_d;
`ifdef GPS_CORR_TRACK_EN
      miss_q       <= miss_d;
`endif
    end
  end

  assign bus.lock       = lock_q;
  assign bus.fail       = fail_q;
  assign bus.done       = done_q;
  assign bus.code_phase = code_phase_q;
  assign bus.corr_count = corr_q;

endmodule

// File: tb/tb_gps_ca_acquire.sv
// tb_gps_ca_acquire: directed scoreboard bench for gps_ca_acquire
// (CORR_LEN=64, THRESH=56). Each expected done response is queued when its
// stimulus is issued; the monitor pops and checks on every done pulse.
module tb_gps_ca_acquire;

  typedef struct packed {
    logic        lock;
    logic        fail;
    logic [9:0]  phase;
    logic [10:0] corr;
    logic        chk_corr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gps_ca_acquire_if bus ();

  gps_ca_acquire #(.CORR_LEN(64), .THRESH(56)) dut (
    .gps_clk_fast (clk),
    .sync_rst_in  (rst),
    .bus          (bus)
  );

  int    total = 0;
  int    bad   = 0;
  int    done_cnt = 0;
  bit    lock_seen = 0;
  exp_t  sb_q[$];
  string sb_name[$];

  logic [1022:0] ca1, ca2;
  int s_sv = 1, s_off = 0, s_inv = 0, k = 0;
  bit s_inv_all = 0;

  // Reference C/A code, chip n at bit n.
  function automatic logic [1022:0] make_ca(input int t1, input int t2);
    logic [1022:0] c;
    bit g1[1:10];
    bit g2[1:10];
    bit f1, f2;
    c = '0;
    for (int i = 1; i <= 10; i++) begin g1[i] = 1; g2[i] = 1; end
    for (int n = 0; n < 1023; n++) begin
      c[n] = g1[10] ^ g2[t1] ^ g2[t2];
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int i = 10; i > 1; i--) begin g1[i] = g1[i-1]; g2[i] = g2[i-1]; end
      g1[1] = f1;
      g2[1] = f2;
    end
    return c;
  endfunction

  function automatic logic [9:0] first10(input logic [1022:0] c);
    logic [9:0] f = '0;
    for (int n = 0; n < 10; n++) f = {f[8:0], c[n]};
    return f;
  endfunction

  function automatic bit stream_chip(input int idx);
    bit c;
    int j;
    if (idx < s_off) c = 1'b0;
    else begin
      j = (idx - s_off) % 1023;
      c = (s_sv == 2) ? ca2[j] : ca1[j];
    end
    if (s_inv_all || ((idx % 64) < s_inv)) c = ~c;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic lk, input logic fl,
                      input logic [9:0] ph, input logic [10:0] cr, input logic cc);
    exp_t e;
    e.lock = lk; e.fail = fl; e.phase = ph; e.corr = cr; e.chk_corr = cc;
    sb_q.push_back(e);
    sb_name.push_back(nm);
  endtask

  task automatic do_start(input logic [5:0] sv);
    bus.sv_num     = sv;
    bus.start      = 1'b1;
    bus.chip_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      bus.chip_in    = stream_chip(k);
      bus.chip_valid = 1'b1;
      k++;
      @(posedge clk); #1;
    end
    bus.chip_valid = 1'b0;
  endtask

  task automatic wait_sb(input string nm, input int budget);
    int c = 0;
    while (sb_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d responses outstanding after timeout, required 0", nm, sb_q.size());
      sb_q.delete();
      sb_name.delete();
    end
  endtask

  task automatic set_stream(input int sv, input int off, input int inv, input bit inv_all);
    s_sv = sv; s_off = off; s_inv = inv; s_inv_all = inv_all;
  endtask

  // Monitor: one line per completed transaction.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (bus.lock) lock_seen = 1;
      if (!rst && bus.done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: done=1 at code_phase=%0d, required no done", bus.code_phase);
        end else begin
          e  = sb_q.pop_front();
          nm = sb_name.pop_front();
          $display("txn %s: lock=%0d fail=%0d code_phase=%0d corr_count=%0d",
                   nm, bus.lock, bus.fail, bus.code_phase, bus.corr_count);
          chk({nm, ".lock"},  32'(bus.lock),       32'(e.lock));
          chk({nm, ".fail"},  32'(bus.fail),       32'(e.fail));
          chk({nm, ".phase"}, 32'(bus.code_phase), 32'(e.phase));
          if (e.chk_corr) chk({nm, ".corr"}, 32'(bus.corr_count), 32'(e.corr));
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.sv_num     = '0;
    bus.start      = 1'b0;
    bus.chip_in    = 1'b0;
    bus.chip_valid = 1'b0;
    ca1 = make_ca(2, 6);
    ca2 = make_ca(3, 7);
    chk("ref_sv1_first10", 32'(first10(ca1)), 32'h320);  // 1100100000
    chk("ref_sv2_first10", 32'(first10(ca2)), 32'h390);  // 1110010000

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.lock",  32'(bus.lock), 0);
    chk("reset.fail",  32'(bus.fail), 0);
    chk("reset.done",  32'(bus.done), 0);
    chk("reset.phase", 32'(bus.code_phase), 0);
    chk("reset.corr",  32'(bus.corr_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Aligned SV1 stream: lock after one window.
    set_stream(1, 0, 0, 0);
    do_start(6'd1);
    push("sv1_aligned", 1, 0, 10'd0, 11'd64, 1);
    feed(64);
    wait_sb("sv1_aligned", 3);

    // Keep streaming, inverted, after lock.
    set_stream(1, 0, 0, 1);
    feed(64);
    @(negedge clk);
`ifdef GPS_CORR_TRACK_EN
    chk("track_loss.lock",  32'(bus.lock), 0);
    chk("track_loss.phase", 32'(bus.code_phase), 1);
    chk("track_loss.corr",  32'(bus.corr_count), 0);
    chk("track_loss.fail",  32'(bus.fail), 0);
`else
    chk("lock_hold.lock",  32'(bus.lock), 1);
    chk("lock_hold.phase", 32'(bus.code_phase), 0);
    chk("lock_hold.corr",  32'(bus.corr_count), 64);
`endif
    chk("single_done_count", 32'(done_cnt), 1);

    // Reset during SEARCH after one slip.
    set_stream(1, 3, 0, 0);
    do_start(6'd1);
    feed(75);
    @(negedge clk);
    chk("pre_reset.phase", 32'(bus.code_phase), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_reset.lock",  32'(bus.lock), 0);
    chk("async_reset.fail",  32'(bus.fail), 0);
    chk("async_reset.done",  32'(bus.done), 0);
    chk("async_reset.phase", 32'(bus.code_phase), 0);
    chk("async_reset.corr",  32'(bus.corr_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Stream delayed by three chips: lock at phase 3 after 4 windows + 3 slips.
    set_stream(1, 3, 0, 0);
    do_start(6'd1);
    push("sv1_offset3", 1, 0, 10'd3, 11'd64, 1);
    feed(4 * 64 + 3);
    wait_sb("sv1_offset3", 3);

    // Exactly THRESH agreements.
    set_stream(1, 0, 8, 0);
    do_start(6'd1);
    push("sv1_inv8", 1, 0, 10'd0, 11'd56, 1);
    feed(64);
    wait_sb("sv1_inv8", 3);

    // One short of THRESH: no lock, slip to phase 1.
    set_stream(1, 0, 9, 0);
    do_start(6'd1);
    feed(64);
    @(negedge clk);
    $display("txn sv1_inv9: lock=%0d code_phase=%0d corr_count=%0d", bus.lock, bus.code_phase, bus.corr_count);
    chk("sv1_inv9.lock",  32'(bus.lock), 0);
    chk("sv1_inv9.fail",  32'(bus.fail), 0);
    chk("sv1_inv9.corr",  32'(bus.corr_count), 55);
    chk("sv1_inv9.phase", 32'(bus.code_phase), 1);

    // Invalid SV: immediate FAIL with done.
    push("bad_sv0", 0, 1, 10'd0, 11'd0, 0);
    do_start(6'd0);
    wait_sb("bad_sv0", 2);

    // SV1 search against an SV2 stream: exhaust all 1023 phases.
    set_stream(2, 0, 0, 0);
    do_start(6'd1);
    lock_seen = 0;
    push("sv1_vs_sv2", 0, 1, 10'd1022, 11'd0, 0);
    feed(1023 * 64 + 1022);
    wait_sb("sv1_vs_sv2", 3);
    chk("sv1_vs_sv2.lock_never", 32'(lock_seen), 0);

    chk("total_done_count", 32'(done_cnt), 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gps_ca_acquire.md
# gps_ca_acquire

Receive-side counterpart of the GPS code transmitter. It accepts a serial C/A chip stream and regenerates the C/A code locally for a selected SV. It then searches code phase by serial correlation: each window counts chip agreements, and the local code is slipped one chip after every failed window. It reports lock, code phase and agreement count to downstream receiver logic.

## Interface
Parameters:
- CORR_LEN, 64: chips per correlation window (2..1023).
- THRESH, 56: minimum agreements in a window to declare or keep lock (≤ CORR_LEN).

Ports:
- gps_clk_fast  in  1  sole clock, rising edge.
- sync_rst_in  in  1  reset; asynchronous, active-high.
- sv_num  in  6  SV select, 1..32; sampled only on an accepted start.
- start  in  1  one-cycle pulse; accepted in any state and restarts the search.
- chip_in  in  1  received C/A chip.
- chip_valid  in  1  qualifies chip_in; at most one chip per cycle.
- lock  out  1  level; high while in LOCK. Reset 0.
- fail  out  1  level; high in FAIL. Reset 0.
- done  out  1  one-cycle pulse on entry to LOCK or FAIL. Reset 0.
- code_phase  out  10  current slip count, 0..1022. Reset 0.
- corr_count  out  11  agreement count of the last completed window. Reset 0.

## Operation
Local generator:
- G1 = 1+x^3+x^10; G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10.
- Both registers load all-ones on start.
- Output chip = G1[10] ^ G2[s1] ^ G2[s2], with (s1,s2) taken from the per-SV tap table.

States: IDLE, SEARCH, SLIP, LOCK, FAIL.
- IDLE → SEARCH on start with sv_num in 1..32. On entry: reload LFSRs, code_phase=0, window and agreement counters = 0.
- IDLE/any → FAIL on start with sv_num 0 or >32. done pulses; code_phase stays 0.
- SEARCH, on each chip_valid:
  - compare chip_in with the local chip and increment agreements on equality;
  - advance the LFSRs;
  - increment the window counter.
- SEARCH, at the end of a window (CORR_LEN-th valid chip):
  - corr_count is updated;
  - if agreements ≥ THRESH → LOCK (lock=1, done pulse);
  - else if code_phase == 1022 → FAIL (done pulse);
  - else → SLIP, with code_phase+1.
- SLIP: the next chip_valid is consumed without comparison and without advancing the LFSRs, which delays local code by one chip. Then → SEARCH with counters cleared.
- LOCK: windows continue back-to-back at the locked phase, with the LFSRs free-running. Behaviour at window end depends on GPS_CORR_TRACK_EN (see Configuration).
- FAIL: holds until start or reset.
- chip_valid low: all counters and LFSRs hold.
- Arithmetic:
  - the agreement counter saturates cannot occur because CORR_LEN ≤ 1023;
  - code_phase never exceeds 1022;
  - the LFSRs wrap naturally at 1023 chips.

## Timing
- start at cycle t → state and counters updated at t+1. A chip_valid at t is ignored.
- First comparison uses the chip_valid at t+1 or later.
- corr_count, lock, fail and done are all registered and change on the clock edge that closes the window. There is no extra latency.
- Simultaneous start and window end: start wins.
- Reset mid-operation: all outputs and state return to reset values immediately. done is not pulsed.
- Time to FAIL: 1023 windows plus 1022 slip chips.

## Configuration
GPS_CORR_TRACK_EN:
- Defined: in LOCK, a window with agreements < THRESH clears lock and goes to SLIP with code_phase+1, wrapping 1022→0. The search then resumes; FAIL is reachable only after 1023 further windows without lock. corr_count updates every window.
- Undefined: LOCK is terminal until start or reset. corr_count freezes at the locking window's value.

## Structure
- Package gps_rx_pkg holds:
  - the state enum;
  - the 32-entry G2 tap-pair table (SV1=(2,6), SV2=(3,7), … per IS-GPS-200);
  - G1/G2 init constants;
  - the SV range limits.
- Sub-module gps_rx_cagen contains the G1/G2 LFSR pair. Ports: load, advance, tap pair, chip out.

## Test plan
- SV1, stream = SV1 code from chip 0 with chip_valid every cycle → lock after 64 chips; code_phase=0, corr_count=64, one done pulse. The first ten local chips must be 1100100000.
- SV1, stream = 3 zero chips followed by SV1 code → lock at code_phase=3 with corr_count=64 after 4 windows plus 3 slip chips.
- Aligned SV1 stream with 8 chips inverted per window → lock with corr_count=56. With 9 inverted → no lock at phase 0.
- Search SV1 while feeding the SV2 code → fail=1 and a done pulse after 1023 windows; lock never asserts.
- start with sv_num=0 → fail=1 and done at t+1; code_phase=0.
- Reset, and with GPS_CORR_TRACK_EN a lost lock:
  - Assert reset mid-SEARCH → all outputs 0 asynchronously.
  - With GPS_CORR_TRACK_EN, lock at phase 0 then invert the stream → lock drops at the next window end and the search resumes with code_phase=1.
